mul_div_unit: RTL

//  Iterative multiply/divide unit for the MIPS150 processor. It complements the

---
 rtl/mul_div_if.sv | 38 +++
 rtl/mul_div_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mul_div_if.sv
// ---------------------------------------------------------------------------
// mul_div_if
//   Datapath <-> multiply/divide unit connection.
//   master : the datapath. It drives start/op/a/b and the MTHI/MTLO write port.
//   slave  : the mul/div unit. It drives busy/done and the HI/LO registers.
// Signals
//   start        request a MULT/MULTU/DIV/DIVU; accepted only while idle
//   op[1:0]      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b[31:0]   rs / rt operands, sampled together with start
//   hi_we, lo_we MTHI / MTLO write enables, using wdata
//   wdata[31:0]  data written by hi_we / lo_we
//   busy         operation in flight
//   done         one-cycle pulse after HI/LO receive a result
//   hi, lo[31:0] architectural HI / LO registers
// ---------------------------------------------------------------------------
interface mul_div_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//   Iterative MULT/MULTU/DIV/DIVU engine for the MIPS150 datapath.
//   Handles one operand bit per cycle: 1 idle/start cycle, 32 CALC cycles and
//   1 FIX cycle. HI/LO are written at the end of FIX, and done pulses in the
//   cycle after that. MTHI/MTLO write HI/LO directly while the unit is idle.
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : mul_div_if.slave (start/op/a/b, hi_we/lo_we/wdata, busy/done/hi/lo)
// Parameters
//   DIV0_LO : value written to LO on divide-by-zero. HI receives the dividend.
// ---------------------------------------------------------------------------
module mul_div_unit #(
  parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
  input  logic     clk,
  input  logic     rst,
  mul_div_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;        // CALC step index, 0..31
  logic        is_div;
  logic        neg_res;    // negate the product or quotient in FIX
  logic        neg_rem;    // remainder takes the dividend's sign
  logic        div0;
  logic [31:0] a_orig;     // raw dividend, returned in HI on divide-by-zero
  logic [31:0] opnd;       // |multiplicand| or |divisor|
  logic [63:0] acc;        // mul: {partial product, multiplier}; div: {rem, quotient}
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [32:0] div_r;
  logic [33:0] div_diff;
  logic [63:0] div_step;
  logic [63:0] prod;
  logic [31:0] quo, rem;

  // Signed ops (op[0]=1) work on magnitudes. The signs are re-applied in FIX.
  assign abs_a = (bus.op[0] && bus.a[31]) ? -bus.a : bus.a;
  assign abs_b = (bus.op[0] && bus.b[31]) ? -bus.b : bus.b;

  // Shift-add: add the multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right by one.
  assign mul_sum  = {1'b0, acc[63:32]} + {1'b0, opnd};
  assign mul_step = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};

  // Restoring division: shift the next dividend bit into the remainder, then
  // try to subtract. The remainder stays below the divisor, so 33 bits hold
  // the shifted value, and the extra bit of div_diff gives the borrow.
  assign div_r    = {acc[63:32], acc[31]};
  assign div_diff = {1'b0, div_r} - {2'b00, opnd};
  assign div_step = div_diff[33] ? {div_r[31:0], acc[30:0], 1'b0}
                                 : {div_diff[31:0], acc[30:0], 1'b1};

  // Sign fix-up. With the magnitude quotient, DIV 0x80000000 / -1 already
  // yields lo=0x80000000, hi=0.
  assign prod = neg_res ? -acc : acc;
  assign quo  = neg_res ? -acc[31:0]  : acc[31:0];
  assign rem  = neg_rem ? -acc[63:32] : acc[63:32];

  // State register
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  // NOTE: the default assignment first means no path leaves state_nxt
  // unassigned, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_CALC;
      S_CALC:  if (cnt == 5'd31) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.busy = (state != S_IDLE);
  end

  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // Operand capture and iteration datapath
  // NOTE: these registers have no reset. Each start loads them before they
  // are read, and a reset only needs to return the FSM to IDLE.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.start) begin
      is_div  <= bus.op[1];
      neg_res <= bus.op[0] & (bus.a[31] ^ bus.b[31]);
      neg_rem <= bus.op[0] & bus.a[31];
      div0    <= (bus.b == 32'd0);
      a_orig  <= bus.a;
      cnt     <= 5'd0;
      if (bus.op[1]) begin
        opnd <= abs_b;
        acc  <= {32'd0, abs_a};
      end else begin
        opnd <= abs_a;
        acc  <= {32'd0, abs_b};
      end
    end else if (state == S_CALC) begin
      acc <= is_div ? div_step : mul_step;
      cnt <= cnt + 5'd1;
    end
  end

  // Architectural HI/LO and the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == S_FIX);
      case (state)
        S_IDLE: begin
          // If start is also asserted in this cycle, the write is dropped.
          if (!bus.start) begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        S_FIX: begin
          if (!is_div) begin
            {hi_q, lo_q} <= prod;
          end else if (div0) begin
            hi_q <= a_orig;
            lo_q <= DIV0_LO;
          end else begin
            hi_q <= rem;
            lo_q <= quo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
